// File: rtl/nfi_gen_scheduler.sv
// nfi_gen_scheduler: run/pause/step/clear sequencing for the NFI engine.
// Paces generations in display frames and flips the display buffer at frame end.
module nfi_gen_scheduler #(
  parameter int PERIOD_FRAMES = 10,
  parameter int GEN_CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_run,
  input  logic                 i_step,
  input  logic                 i_clear,
  input  logic                 i_frame_end,
  output logic                 o_nfi_start,
  input  logic                 i_nfi_done,
  output logic                 o_clear_start,
  input  logic                 i_clear_done,
  output logic                 o_buf_sel,
  output logic [GEN_CNT_W-1:0] o_gen_cnt,
  output logic                 o_busy,
  output logic                 o_edit_allowed
);

  localparam int FW =
    (PERIOD_FRAMES > 1) ? $clog2(PERIOD_FRAMES) : 1;
  localparam logic [FW-1:0] FMAX = FW'(PERIOD_FRAMES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COMPUTE,
    S_SWAP_WAIT,
    S_CLEARING
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [FW-1:0]         r_frm_cnt;
  logic                  r_clr_pend;
  logic                  r_nfi_start;
  logic                  r_clear_start;
  logic                  r_buf_sel;
  logic [GEN_CNT_W-1:0]  r_gen_cnt;
  logic                  w_go_compute;
  logic                  w_go_clear;
  logic                  w_swap;
  logic                  w_clr_fin;
  logic                  w_trigger;

  // A pending clear always beats a new generation
  assign w_trigger = (i_run && (r_frm_cnt == FMAX))
                   || (!i_run && i_step);

  // Next-state decode and per-transition strobes
  always_comb begin
    w_next       = r_state;
    w_go_compute = 1'b0;
    w_go_clear   = 1'b0;
    w_swap       = 1'b0;
    w_clr_fin    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (r_clr_pend) begin
          w_next     = S_CLEARING;
          w_go_clear = 1'b1;
        end else if (w_trigger) begin
          w_next       = S_COMPUTE;
          w_go_compute = 1'b1;
        end
      end
      S_COMPUTE: begin
        if (i_nfi_done) w_next = S_SWAP_WAIT;
      end
      S_SWAP_WAIT: begin
        if (i_frame_end) begin
          w_next = S_IDLE;
          w_swap = 1'b1;
        end
      end
      S_CLEARING: begin
        if (i_clear_done) begin
          w_next    = S_IDLE;
          w_clr_fin = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Start pulses land in the first cycle of the new state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_nfi_start   <= 1'b0;
      r_clear_start <= 1'b0;
    end else begin
      r_nfi_start   <= w_go_compute;
      r_clear_start <= w_go_clear;
    end
  end

  // Clear request latch; a new request wins over consumption
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_clr_pend <= 1'b0;
    else if (i_clear)    r_clr_pend <= 1'b1;
    else if (w_go_clear) r_clr_pend <= 1'b0;
  end

  // Frame pacing counter, saturating at the trigger value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frm_cnt <= '0;
    end else if (!i_run || r_nfi_start || i_clear_done) begin
      r_frm_cnt <= '0;
    end else if (i_frame_end && (r_frm_cnt != FMAX)) begin
      r_frm_cnt <= r_frm_cnt + 1'b1;
    end
  end

  // Buffer select flips only at frame end; clear resets the count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf_sel <= 1'b0;
      r_gen_cnt <= '0;
    end else if (w_swap) begin
      r_buf_sel <= ~r_buf_sel;
      r_gen_cnt <= r_gen_cnt + 1'b1;
    end else if (w_clr_fin) begin
      r_gen_cnt <= '0;
    end
  end

  assign o_nfi_start    = r_nfi_start;
  assign o_clear_start  = r_clear_start;
  assign o_buf_sel      = r_buf_sel;
  assign o_gen_cnt      = r_gen_cnt;
  assign o_busy         = (r_state != S_IDLE);
  assign o_edit_allowed = (r_state == S_IDLE)
                        && !i_run && !r_clr_pend;

endmodule

// File: tb/tb_nfi_gen_scheduler.sv
// tb_nfi_gen_scheduler: table vectors, corner sequences and
// randomized traffic against a behavioural scheduler model.
module tb_nfi_gen_scheduler;

  localparam int P  = 3;
  localparam int GW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_run = 1'b0;
  logic          i_step = 1'b0;
  logic          i_clear = 1'b0;
  logic          i_frame_end = 1'b0;
  logic          i_nfi_done = 1'b0;
  logic          i_clear_done = 1'b0;
  logic          o_nfi_start;
  logic          o_clear_start;
  logic          o_buf_sel;
  logic [GW-1:0] o_gen_cnt;
  logic          o_busy;
  logic          o_edit_allowed;

  nfi_gen_scheduler #(
    .PERIOD_FRAMES(P),
    .GEN_CNT_W(GW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .i_run(i_run),
    .i_step(i_step),
    .i_clear(i_clear),
    .i_frame_end(i_frame_end),
    .o_nfi_start(o_nfi_start),
    .i_nfi_done(i_nfi_done),
    .o_clear_start(o_clear_start),
    .i_clear_done(i_clear_done),
    .o_buf_sel(o_buf_sel),
    .o_gen_cnt(o_gen_cnt),
    .o_busy(o_busy),
    .o_edit_allowed(o_edit_allowed)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: generation in flight, clear in flight
  bit m_gen_on;
  bit m_done_seen;
  bit m_clearing;
  bit m_pend;
  bit m_nfi;
  bit m_clr;
  bit m_buf;
  int m_frames;
  int m_gen;

  function automatic void m_reset();
    m_gen_on    = 0;
    m_done_seen = 0;
    m_clearing  = 0;
    m_pend      = 0;
    m_nfi       = 0;
    m_clr       = 0;
    m_buf       = 0;
    m_frames    = 0;
    m_gen       = 0;
  endfunction

  function automatic void m_step(
    bit run, bit step, bit clr, bit fe, bit nd, bit cd
  );
    bit idle;
    bit sc;
    bit sg;
    idle = !m_gen_on && !m_clearing;
    sc   = idle && m_pend;
    sg   = idle && !m_pend &&
           ((run && m_frames == P - 1) || (!run && step));
    if (!run || m_nfi || cd) m_frames = 0;
    else if (fe && m_frames < P - 1) m_frames++;
    if (m_gen_on) begin
      if (!m_done_seen) begin
        if (nd) m_done_seen = 1;
      end else if (fe) begin
        m_buf       = !m_buf;
        m_gen       = (m_gen + 1) % (1 << GW);
        m_gen_on    = 0;
        m_done_seen = 0;
      end
    end
    if (m_clearing && cd) begin
      m_gen      = 0;
      m_clearing = 0;
    end
    if (sg) m_gen_on = 1;
    if (sc) m_clearing = 1;
    m_pend = clr | (m_pend & !sc);
    m_nfi  = sg;
    m_clr  = sc;
  endfunction

  task automatic chk(
    input string nm, input logic [31:0] act, input logic [31:0] exp
  );
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d, expected %0d",
               nm, $time, act, exp);
    end
  endtask

  task automatic chk_model(input bit run);
    chk("nfi_start", 32'(o_nfi_start), 32'(m_nfi));
    chk("clear_start", 32'(o_clear_start), 32'(m_clr));
    chk("buf_sel", 32'(o_buf_sel), 32'(m_buf));
    chk("gen_cnt", 32'(o_gen_cnt), 32'(m_gen));
    chk("busy", 32'(o_busy), 32'(m_gen_on | m_clearing));
    chk("edit", 32'(o_edit_allowed),
        32'(!m_gen_on && !m_clearing && !run && !m_pend));
  endtask

  task automatic drive(
    input bit run, input bit step, input bit clr,
    input bit fe, input bit nd, input bit cd
  );
    i_run        = run;
    i_step       = step;
    i_clear      = clr;
    i_frame_end  = fe;
    i_nfi_done   = nd;
    i_clear_done = cd;
  endtask

  // One clock: drive, check before the edge, advance model
  task automatic cyc(
    input bit run, input bit step, input bit clr,
    input bit fe, input bit nd, input bit cd
  );
    @(negedge clk);
    drive(run, step, clr, fe, nd, cd);
    #1;
    chk_model(run);
    m_step(run, step, clr, fe, nd, cd);
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    m_reset();
    @(negedge clk);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_nfi", 32'(o_nfi_start), 32'd0);
    chk("rst_clr", 32'(o_clear_start), 32'd0);
    chk("rst_buf", 32'(o_buf_sel), 32'd0);
    chk("rst_gen", 32'(o_gen_cnt), 32'd0);
    rst_n = 1'b1;
  endtask

  task automatic one_gen_step();
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0, 0);
  endtask

  typedef struct {
    bit run, step, clr, fe, nd, cd;
    bit e_nfi, e_clr, e_buf;
    int e_gen;
    bit e_busy, e_edit;
  } vec_t;

  vec_t tbl[14];

  initial begin
    int ps;
    int first_start;
    bit run;

    // step, ignored step, swap, then clear from idle
    tbl[0]  = '{0,0,0,0,0,0, 0,0,0,0,0,1};
    tbl[1]  = '{0,1,0,0,0,0, 0,0,0,0,0,1};
    tbl[2]  = '{0,0,0,0,0,0, 1,0,0,0,1,0};
    tbl[3]  = '{0,1,0,0,0,0, 0,0,0,0,1,0};
    tbl[4]  = '{0,0,0,0,1,0, 0,0,0,0,1,0};
    tbl[5]  = '{0,0,0,0,0,0, 0,0,0,0,1,0};
    tbl[6]  = '{0,0,0,1,0,0, 0,0,0,0,1,0};
    tbl[7]  = '{0,0,0,0,0,0, 0,0,1,1,0,1};
    tbl[8]  = '{0,0,1,0,0,0, 0,0,1,1,0,1};
    tbl[9]  = '{0,0,0,0,0,0, 0,0,1,1,0,0};
    tbl[10] = '{0,0,0,0,0,0, 0,1,1,1,1,0};
    tbl[11] = '{0,0,0,0,0,1, 0,0,1,1,1,0};
    tbl[12] = '{0,0,0,0,0,0, 0,0,1,0,0,1};
    tbl[13] = '{1,0,0,0,1,0, 0,0,1,0,0,0};

    do_reset();
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      drive(tbl[i].run, tbl[i].step, tbl[i].clr,
            tbl[i].fe, tbl[i].nd, tbl[i].cd);
      #1;
      chk($sformatf("t%0d_nfi", i), 32'(o_nfi_start),
          32'(tbl[i].e_nfi));
      chk($sformatf("t%0d_clr", i), 32'(o_clear_start),
          32'(tbl[i].e_clr));
      chk($sformatf("t%0d_buf", i), 32'(o_buf_sel),
          32'(tbl[i].e_buf));
      chk($sformatf("t%0d_gen", i), 32'(o_gen_cnt),
          32'(tbl[i].e_gen));
      chk($sformatf("t%0d_busy", i), 32'(o_busy),
          32'(tbl[i].e_busy));
      chk($sformatf("t%0d_edit", i), 32'(o_edit_allowed),
          32'(tbl[i].e_edit));
    end

    // Run-mode pacing with frame_end every 20 clocks
    do_reset();
    ps = -100;
    first_start = -1;
    for (int k = 0; k < 200; k++) begin
      cyc(1, 0, 0, (k % 20) == 19, k == ps + 5, 0);
      if (o_nfi_start) begin
        ps = k;
        if (first_start < 0) first_start = k;
      end
    end
    chk("run_first_start", 32'(first_start), 32'd41);
    cyc(1, 0, 0, 0, 0, 0);
    chk("run_gen_200", 32'(o_gen_cnt), 32'd4);

    // done coincident with frame_end must not swap
    do_reset();
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("coinc_noswap_buf", 32'(o_buf_sel), 32'd0);
    chk("coinc_busy", 32'(o_busy), 32'd1);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("coinc_swap_buf", 32'(o_buf_sel), 32'd1);
    chk("coinc_gen", 32'(o_gen_cnt), 32'd1);

    // 16 generations wrap a 4-bit counter
    do_reset();
    for (int g = 0; g < 15; g++) one_gen_step();
    cyc(0, 0, 0, 0, 0, 0);
    chk("wrap_gen15", 32'(o_gen_cnt), 32'd15);
    one_gen_step();
    cyc(0, 0, 0, 0, 0, 0);
    chk("wrap_gen0", 32'(o_gen_cnt), 32'd0);
    chk("wrap_buf0", 32'(o_buf_sel), 32'd0);

    // Asynchronous reset while waiting to swap
    do_reset();
    one_gen_step();
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("arst_pre_busy", 32'(o_busy), 32'd1);
    chk("arst_pre_buf", 32'(o_buf_sel), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(o_busy), 32'd0);
    chk("arst_buf", 32'(o_buf_sel), 32'd0);
    chk("arst_gen", 32'(o_gen_cnt), 32'd0);
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 0, 0, 0, 0, 0);
    chk("arst_edit", 32'(o_edit_allowed), 32'd1);

    // Randomized traffic against the model
    do_reset();
    run = 0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 99) == 0) run = !run;
      cyc(run,
          $urandom_range(0, 99) < 8,
          $urandom_range(0, 99) < 2,
          (k % 20) == 19,
          $urandom_range(0, 99) < 15,
          $urandom_range(0, 99) < 15);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
